// File: rtl/hilo_mdu_sequencer.sv
// rtl/hilo_mdu_sequencer.sv - iterative shift-add multiply/accumulate unit owning HI/LO
module hilo_mdu_sequencer #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoRead,
    input  logic        Flush,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    localparam int         N     = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] N_CNT = 6'(N);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;
    state_t state, state_nxt;

    logic [63:0] mcand;
    logic [63:0] prod;
    logic [63:0] pp_sum;
    logic [63:0] prod_signed;
    logic [63:0] fix_val;
    logic [31:0] mplier;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [5:0]  count;
    logic [1:0]  op_q;
    logic        neg;
    logic        op_signed;
    logic        issue_mul;
    logic        issue_mthi;
    logic        issue_mtlo;
    logic        fix_write;
    logic        done_set;

    // Signed ops multiply magnitudes; the sign is reapplied in FIX.
    assign op_signed = (Op[1:0] != 2'b01);
    assign mag_a     = (op_signed && A[31]) ? (~A + 32'd1) : A;
    assign mag_b     = (op_signed && B[31]) ? (~B + 32'd1) : B;

    always_comb begin
        state_nxt  = state;
        issue_mul  = 1'b0;
        issue_mthi = 1'b0;
        issue_mtlo = 1'b0;
        fix_write  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    if (!Op[2]) begin
                        issue_mul = 1'b1;
                        state_nxt = ST_CALC;
                    end else if (Op == 3'b100) begin
                        issue_mthi = 1'b1;
                    end else if (Op == 3'b101) begin
                        issue_mtlo = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (Flush)
                    state_nxt = ST_IDLE;
                else if (count == 6'd1)
                    state_nxt = ST_FIX;
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                fix_write = !Flush;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i])
                pp_sum = pp_sum + (mcand << i);
        end
    end

    assign prod_signed = neg ? (~prod + 64'd1) : prod;

    always_comb begin
        fix_val = prod_signed;
        case (op_q)
            2'b10:   fix_val = {Hi, Lo} + prod_signed;
            2'b11:   fix_val = {Hi, Lo} - prod_signed;
            default: fix_val = prod_signed;
        endcase
    end

    assign Busy     = (state != ST_IDLE);
    assign Stall    = Busy & (Start | HiLoRead);
    // A write landing right after a Done cycle is not re-flagged, keeping Done a single-cycle pulse.
    assign done_set = (fix_write | issue_mthi | issue_mtlo) & ~Done;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Hi     <= '0;
            Lo     <= '0;
            Done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
            neg    <= 1'b0;
            op_q   <= '0;
        end else begin
            Done <= done_set;
            case (state)
                ST_IDLE: begin
                    if (issue_mul) begin
                        mcand  <= {32'd0, mag_a};
                        mplier <= mag_b;
                        prod   <= '0;
                        count  <= N_CNT;
                        neg    <= op_signed & (A[31] ^ B[31]);
                        op_q   <= Op[1:0];
                    end
                    if (issue_mthi)
                        Hi <= A;
                    if (issue_mtlo)
                        Lo <= A;
                end
                ST_CALC: begin
                    prod   <= prod + pp_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    count  <= count - 6'd1;
                end
                ST_FIX: begin
                    if (fix_write)
                        {Hi, Lo} <= fix_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// tb/tb_hilo_mdu_sequencer.sv - vector table, corner sequences and randomized model check
module tb_hilo_mdu_sequencer;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoRead;
    logic        Flush;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int LAT = 18;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] pre;
        logic [63:0] exp;
        string       name;
    } vec_t;
    vec_t vq[$];

    hilo_mdu_sequencer #(.BITS_PER_CYCLE(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiLoRead(HiLoRead), .Flush(Flush), .Busy(Busy), .Stall(Stall),
        .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic rd, input logic fl);
        @(posedge Clk);
        #2;
        Start = st; Op = op; A = a; B = b; HiLoRead = rd; Flush = fl;
        #1;
    endtask

    task automatic idle_cycle();
        next_cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        next_cycle(1'b1, 3'b100, h, 32'd0, 1'b0, 1'b0);
        idle_cycle();
        check("mthi", {35'd0, Busy, Done, h[29:0]}, {35'd0, 1'b0, 1'b1, h[29:0]});
        check("mthi_hi", {35'd0, Hi}, {35'd0, h});
        next_cycle(1'b1, 3'b101, l, 32'd0, 1'b0, 1'b0);
        idle_cycle();
        check("mtlo", {2'b00, Busy, Done, Hi, Lo}, {2'b00, 1'b0, 1'b1, h, l});
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] pre, input logic [63:0] exp, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.pre = pre; v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    task automatic run_mul(input vec_t v);
        set_hilo(v.pre[63:32], v.pre[31:0]);
        next_cycle(1'b1, v.op, v.a, v.b, 1'b0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            idle_cycle();
            if (k < LAT)
                check({v.name, "_busy"}, {1'b0, Busy, Done, Hi, Lo}, {1'b0, 1'b1, 1'b0, v.pre});
            else
                check({v.name, "_result"}, {1'b0, Busy, Done, Hi, Lo}, {1'b0, 1'b0, 1'b1, v.exp});
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
        logic signed [63:0] sp;
        logic [63:0]        up;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'd0, a} * {32'd0, b};
        case (op)
            3'b000:  return sp;
            3'b001:  return up;
            3'b010:  return hilo + sp;
            3'b011:  return hilo - sp;
            3'b100:  return {a, hilo[31:0]};
            3'b101:  return {hilo[63:32], a};
            default: return hilo;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] m_hilo;
        logic [63:0] nxt;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rd;
        logic        busy_e;
        logic        done_e;
        logic [63:0] hilo_e;
        int          fl_at;

        Rst_n = 1'b0; Start = 1'b0; Op = 3'b000; A = '0; B = '0; HiLoRead = 1'b0; Flush = 1'b0;
        #3;
        check("reset_state", {Busy, Stall, Done, Hi, Lo}, 67'd0);
        @(posedge Clk);
        #2;
        Rst_n = 1'b1;

        add_vec(3'b000, 32'hFFFF_FFFD, 32'd7,        64'd0, 64'hFFFF_FFFF_FFFF_FFEB, "mult_m3x7");
        add_vec(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, "multu_max");
        add_vec(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_0000_0001, "mult_m1xm1");
        add_vec(3'b010, 32'd2, 32'd3, 64'h0000_0000_0000_000A, 64'h0000_0000_0000_0010, "madd_2x3");
        add_vec(3'b011, 32'd4, 32'd5, 64'h0000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFFC, "msub_4x5");
        add_vec(3'b000, 32'h8000_0000, 32'h8000_0000, 64'd7, 64'h4000_0000_0000_0000, "mult_min_sq");
        add_vec(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, "mult_min_m1");
        add_vec(3'b001, 32'h8000_0000, 32'd2, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, "multu_carry");
        add_vec(3'b010, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "madd_neg");
        add_vec(3'b011, 32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0005, "msub_neg");
        add_vec(3'b010, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "madd_wrap");
        foreach (vq[i]) run_mul(vq[i]);

        // Stall from HiLoRead held from cycle 5
        set_hilo(32'd0, 32'd0);
        next_cycle(1'b1, 3'b000, 32'd5, 32'd6, 1'b0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            next_cycle(1'b0, 3'b000, 32'd0, 32'd0, k >= 5, 1'b0);
            if (k < 5)
                check("rd_nostall", {65'd0, Busy, Stall}, {65'd0, 1'b1, 1'b0});
            else if (k < LAT)
                check("rd_stall", {65'd0, Busy, Stall}, {65'd0, 1'b1, 1'b1});
            else
                check("rd_release", {Busy, Stall, Done, Hi, Lo}, {1'b0, 1'b0, 1'b1, 64'd30});
        end

        // Start held while busy is stalled, then accepted once idle
        set_hilo(32'd0, 32'd0);
        next_cycle(1'b1, 3'b000, 32'd2, 32'd3, 1'b0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            next_cycle(1'b1, 3'b100, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0);
            if (k < LAT)
                check("start_stall", {Busy, Stall, Done, Hi, Lo}, {1'b1, 1'b1, 1'b0, 64'd0});
            else
                check("start_release", {Busy, Stall, Done, Hi, Lo}, {1'b0, 1'b0, 1'b1, 64'd6});
        end
        idle_cycle();
        check("held_mthi", {Busy, Stall, Done, Hi, Lo}, {1'b0, 1'b0, 1'b0, 32'h0000_DEAD, 32'd6});

        // Flush during CALC and during FIX
        set_hilo(32'h11, 32'h22);
        for (int f = 0; f < 2; f++) begin
            fl_at = (f == 0) ? 8 : 17;
            next_cycle(1'b1, 3'b000, 32'd7, 32'd7, 1'b0, 1'b0);
            for (int k = 1; k <= 20; k++) begin
                next_cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, k == fl_at);
                check(f == 0 ? "flush_calc" : "flush_fix", {Busy, Stall, Done, Hi, Lo},
                      {k <= fl_at, 1'b0, 1'b0, 32'h11, 32'h22});
            end
        end

        // Flush with Start in IDLE, then reserved ops
        next_cycle(1'b1, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1);
        next_cycle(1'b1, 3'b100, 32'hBEEF, 32'd0, 1'b0, 1'b1);
        check("flush_idle_mul", {Busy, Stall, Done, Hi, Lo}, {3'b000, 32'h11, 32'h22});
        next_cycle(1'b1, 3'b110, 32'hBEEF, 32'd1, 1'b0, 1'b0);
        check("flush_idle_mthi", {Busy, Stall, Done, Hi, Lo}, {3'b000, 32'h11, 32'h22});
        next_cycle(1'b1, 3'b111, 32'hBEEF, 32'd1, 1'b0, 1'b0);
        check("reserved_110", {Busy, Stall, Done, Hi, Lo}, {3'b000, 32'h11, 32'h22});
        idle_cycle();
        check("reserved_111", {Busy, Stall, Done, Hi, Lo}, {3'b000, 32'h11, 32'h22});

        // Asynchronous reset mid-multiply
        set_hilo(32'h55, 32'h66);
        next_cycle(1'b1, 3'b000, 32'd9, 32'd9, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) next_cycle(1'b0, 3'b000, 32'd0, 32'd0, k == 10, 1'b0);
        check("pre_reset_stall", {65'd0, Busy, Stall}, {65'd0, 1'b1, 1'b1});
        Rst_n = 1'b0;
        #1;
        check("mid_reset", {Busy, Stall, Done, Hi, Lo}, 67'd0);
        @(posedge Clk);
        #2;
        Rst_n = 1'b1; HiLoRead = 1'b0;
        begin
            vec_t v;
            v.op = 3'b000; v.a = 32'd2; v.b = 32'd3; v.pre = 64'd0; v.exp = 64'd6; v.name = "post_reset";
            run_mul(v);
        end

        // Randomized transactions against the arithmetic model
        m_hilo = {$urandom, $urandom};
        set_hilo(m_hilo[63:32], m_hilo[31:0]);
        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            a = rnd_val();
            b = rnd_val();
            fl_at = (!op[2] && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 0;
            nxt = model(op, a, b, m_hilo);
            next_cycle(1'b1, op, a, b, 1'($urandom_range(0, 1)), 1'b0);
            check("rnd_issue", {Busy, Stall, Done, Hi, Lo}, {3'b000, m_hilo});
            for (int k = 1; k <= 20; k++) begin
                rd = 1'($urandom_range(0, 1));
                next_cycle(1'b0, 3'b000, 32'd0, 32'd0, rd, k == fl_at);
                if (!op[2]) begin
                    busy_e = (fl_at != 0) ? (k <= fl_at) : (k < LAT);
                    done_e = (fl_at == 0) && (k == LAT);
                    hilo_e = (fl_at == 0 && k >= LAT) ? nxt : m_hilo;
                end else begin
                    busy_e = 1'b0;
                    done_e = (op[1] == 1'b0) && (k == 1);
                    hilo_e = nxt;
                end
                check("rnd_cycle", {Busy, Stall, Done, Hi, Lo}, {busy_e, busy_e & rd, done_e, hilo_e});
            end
            if (fl_at == 0) m_hilo = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
